// File: rtl/cpu_execute_mc.sv
// Execute stage (2a->3a) of the stack CPU: single-cycle ALU plus an iterative
// multiply/divide unit that holds upstream through stall_2a; kill_4a squashes.
module cpu_execute_mc #(
  parameter int unsigned DW = 32,
  parameter int unsigned TW = 3,
  parameter int unsigned IW = 48,
  parameter int unsigned PW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_2a,
  output logic               stall_2a,
  input  logic [4:0]         alu__op_2a,
  input  logic [1:0]         c__alu_left_2a,
  input  logic [1:0]         c__alu_right_2a,
  input  logic [1:0]         c__branch_2a,
  input  logic [2:0]         c__to_push_2a,
  input  logic               c__r0_2a,
  input  logic               c__r1_2a,
  input  logic [IW-1:0]      instruction_2a,
  input  logic [DW-1:0]      pc_2a,
  input  logic [DW-1:0]      pc_1a,
  input  logic [DW+TW-1:0]   st__top_0_2a,
  input  logic [DW+TW-1:0]   st__top_n_2a,
  input  logic [PW-1:0]      st__to_pop_2a,
  input  logic               kill_4a,
  output logic               valid_3a,
  output logic               alu__cond_3a,
  output logic [DW-1:0]      alu__out_3a,
  output logic [1:0]         c__branch_3a,
  output logic [2:0]         c__to_push_3a,
  output logic [PW-1:0]      st__to_pop_3a,
  output logic [IW-1:0]      instruction_3a,
  output logic [DW-1:0]      pc_3a,
  output logic [DW+TW-1:0]   r0_3a,
  output logic [DW+TW-1:0]   r1_3a,
  output logic               md_busy
);

  localparam int unsigned SW  = DW + TW;
  localparam int unsigned SHW = $clog2(DW);
  localparam int unsigned CW  = $clog2(DW);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SHL   = 5'd5;
  localparam logic [4:0] OP_SHR   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_EQ    = 5'd8;
  localparam logic [4:0] OP_LT    = 5'd9;
  localparam logic [4:0] OP_LTU   = 5'd10;
  localparam logic [4:0] OP_PASSL = 5'd11;
  localparam logic [4:0] OP_PASSR = 5'd12;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_DIVU  = 5'd17;
  localparam logic [4:0] OP_REMU  = 5'd18;

  localparam logic [1:0] SRC_IMM  = 2'd0;
  localparam logic [1:0] SRC_STK0 = 2'd1;
  localparam logic [1:0] SRC_STK1 = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e state_q, state_d;

  logic [DW-1:0] left_c, right_c;
  logic [DW-1:0] alu_out_c;
  logic          alu_cond_c;
  logic          alu_is_cmp_c;
  logic          alu_known_c;
  logic [SHW-1:0] shamt_c;
  logic          is_md_c;

  logic          md_accept_c, md_step_c, md_done_c, single_c;

  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    md_op_q, md_op_d;
  logic [DW:0]   rem_sh_c;
  logic [DW-1:0] div_sub_c;
  logic          div_ge_c;
  logic [DW-1:0] md_out_c;

  logic          valid_q, valid_d;
  logic          cond_q, cond_d;
  logic [DW-1:0] out_q, out_d;
  logic [1:0]    branch_q, branch_d;
  logic [2:0]    push_q, push_d;
  logic [PW-1:0] pop_q, pop_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [SW-1:0] r0_q, r0_d;
  logic [SW-1:0] r1_q, r1_d;

  // Operand selection; the right-hand alternate source forwards the live r1_3a data bits
  always_comb begin : operand_mux
    left_c  = '0;
    right_c = '0;
    case (c__alu_left_2a)
      SRC_IMM:  left_c = instruction_2a[DW-1:0];
      SRC_STK0: left_c = st__top_0_2a[DW-1:0];
      SRC_STK1: left_c = st__top_n_2a[DW-1:0];
      default:  left_c = pc_1a;
    endcase
    case (c__alu_right_2a)
      SRC_IMM:  right_c = instruction_2a[DW-1:0];
      SRC_STK0: right_c = st__top_0_2a[DW-1:0];
      SRC_STK1: right_c = st__top_n_2a[DW-1:0];
      default:  right_c = r1_q[DW-1:0];
    endcase
  end

  // Single-cycle ALU; unknown codes give out 0 and cond 0
  always_comb begin : alu
    alu_out_c    = '0;
    alu_is_cmp_c = 1'b0;
    alu_known_c  = 1'b1;
    shamt_c      = right_c[SHW-1:0];
    case (alu__op_2a)
      OP_ADD:   alu_out_c = left_c + right_c;
      OP_SUB:   alu_out_c = left_c - right_c;
      OP_AND:   alu_out_c = left_c & right_c;
      OP_OR:    alu_out_c = left_c | right_c;
      OP_XOR:   alu_out_c = left_c ^ right_c;
      OP_SHL:   alu_out_c = left_c << shamt_c;
      OP_SHR:   alu_out_c = left_c >> shamt_c;
      OP_SRA:   alu_out_c = DW'($signed(left_c) >>> shamt_c);
      OP_EQ: begin
        alu_is_cmp_c = 1'b1;
        alu_out_c    = DW'(left_c == right_c);
      end
      OP_LT: begin
        alu_is_cmp_c = 1'b1;
        alu_out_c    = DW'($signed(left_c) < $signed(right_c));
      end
      OP_LTU: begin
        alu_is_cmp_c = 1'b1;
        alu_out_c    = DW'(left_c < right_c);
      end
      OP_PASSL: alu_out_c = left_c;
      OP_PASSR: alu_out_c = right_c;
      default:  alu_known_c = 1'b0;
    endcase
    alu_cond_c = alu_is_cmp_c ? alu_out_c[0] : (alu_known_c && (alu_out_c == '0));
  end

  assign is_md_c = (alu__op_2a == OP_MUL) || (alu__op_2a == OP_DIVU) || (alu__op_2a == OP_REMU);

  always_ff @(posedge clk) begin : md_state_reg
    if (rst) state_q <= MD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : md_next_state
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (in_valid_2a && is_md_c && !kill_4a) state_d = MD_BUSY;
      MD_BUSY: begin
        if (kill_4a)                        state_d = MD_IDLE;
        else if (cnt_q == CW'(DW - 1))      state_d = MD_DONE;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin : md_outputs
    stall_2a    = 1'b0;
    md_accept_c = 1'b0;
    md_step_c   = 1'b0;
    md_done_c   = 1'b0;
    single_c    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        md_accept_c = in_valid_2a && is_md_c && !kill_4a;
        single_c    = in_valid_2a && !is_md_c && !kill_4a;
        stall_2a    = md_accept_c;
      end
      MD_BUSY: begin
        md_step_c = !kill_4a;
        stall_2a  = !kill_4a;
      end
      MD_DONE: md_done_c = !kill_4a;
      default: ;
    endcase
  end

  // Restoring-division step: acc holds the partial remainder, opa shifts dividend out / quotient in
  assign rem_sh_c  = {acc_q, opa_q[DW-1]};
  assign div_ge_c  = rem_sh_c >= {1'b0, opb_q};
  assign div_sub_c = DW'(rem_sh_c - {1'b0, opb_q});
  assign md_out_c  = (md_op_q == OP_DIVU) ? opa_q : acc_q;

  always_comb begin : md_datapath_next
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    if (md_accept_c) begin
      acc_d   = '0;
      opa_d   = left_c;
      opb_d   = right_c;
      cnt_d   = '0;
      md_op_d = alu__op_2a;
    end else if (md_step_c) begin
      cnt_d = cnt_q + CW'(1);
      if (md_op_q == OP_MUL) begin
        if (opb_q[0]) acc_d = acc_q + opa_q;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end else if (div_ge_c) begin
        acc_d = div_sub_c;
        opa_d = {opa_q[DW-2:0], 1'b1};
      end else begin
        acc_d = rem_sh_c[DW-1:0];
        opa_d = {opa_q[DW-2:0], 1'b0};
      end
    end
  end

  // 3a capture: a live single-cycle op or a finished multiply/divide, otherwise a bubble
  always_comb begin : stage_3a_next
    valid_d  = 1'b0;
    cond_d   = 1'b0;
    out_d    = '0;
    branch_d = '0;
    push_d   = '0;
    pop_d    = '0;
    instr_d  = '0;
    pc_d     = '0;
    r0_d     = r0_q;
    r1_d     = r1_q;
    if (single_c || md_done_c) begin
      valid_d  = 1'b1;
      out_d    = md_done_c ? md_out_c : alu_out_c;
      cond_d   = md_done_c ? (md_out_c == '0) : alu_cond_c;
      branch_d = c__branch_2a;
      push_d   = c__to_push_2a;
      pop_d    = st__to_pop_2a;
      instr_d  = instruction_2a;
      pc_d     = pc_2a;
      if (c__r0_2a) r0_d = st__top_0_2a;
      if (c__r1_2a) r1_d = st__top_n_2a;
    end
  end

  always_ff @(posedge clk) begin : regs
    if (rst) begin
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      md_op_q  <= '0;
      valid_q  <= 1'b0;
      cond_q   <= 1'b0;
      out_q    <= '0;
      branch_q <= '0;
      push_q   <= '0;
      pop_q    <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      md_op_q  <= md_op_d;
      valid_q  <= valid_d;
      cond_q   <= cond_d;
      out_q    <= out_d;
      branch_q <= branch_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      r0_q     <= r0_d;
      r1_q     <= r1_d;
    end
  end

  assign valid_3a       = valid_q;
  assign alu__cond_3a   = cond_q;
  assign alu__out_3a    = out_q;
  assign c__branch_3a   = branch_q;
  assign c__to_push_3a  = push_q;
  assign st__to_pop_3a  = pop_q;
  assign instruction_3a = instr_q;
  assign pc_3a          = pc_q;
  assign r0_3a          = r0_q;
  assign r1_3a          = r1_q;
  assign md_busy        = (state_q != MD_IDLE);

endmodule
